soc_event_bus_tx: RTL and testbench

SOC_EVENT_BUS_TX -- requirements
Module: soc_event_bus_tx

---
 rtl/soc_event_bus_tx.sv | 132 +++++++++++++
 tb/tb_soc_event_bus_tx.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/soc_event_bus_tx.sv
// Event-source transmitter: round-robin arbitration of per-channel events into a
// toggle-token slot ring whose read tokens come from another clock domain.
module soc_event_bus_tx #(
  parameter int NB_CHAN      = 4,
  parameter int EVNT_WIDTH   = 8,
  parameter int BUFFER_WIDTH = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic [NB_CHAN-1:0]                 evt_valid_i,
  input  logic [NB_CHAN*EVNT_WIDTH-1:0]      evt_data_i,
  output logic [NB_CHAN-1:0]                 evt_ack_o,
  output logic [BUFFER_WIDTH-1:0]            events_wt_o,
  input  logic [BUFFER_WIDTH-1:0]            events_rp_i,
  output logic [BUFFER_WIDTH*EVNT_WIDTH-1:0] events_da_o,
  output logic                               full_o,
  output logic [15:0]                        drop_cnt_o
);

  localparam int WPW = (BUFFER_WIDTH > 1) ? $clog2(BUFFER_WIDTH) : 1;
  localparam int CHW = (NB_CHAN > 1) ? $clog2(NB_CHAN) : 1;
  localparam logic [WPW-1:0] WP_LAST = WPW'(BUFFER_WIDTH - 1);
  localparam logic [CHW-1:0] CH_LAST = CHW'(NB_CHAN - 1);

  logic [BUFFER_WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [BUFFER_WIDTH-1:0] rp_sync;
  logic [BUFFER_WIDTH-1:0] wt_q, wt_d;
  logic [NB_CHAN-1:0]      ack_q, ack_d;
  logic [WPW-1:0]          wp_q, wp_d;
  logic [CHW-1:0]          rr_q, rr_d;
  logic [15:0]             drop_q, drop_d;

  logic [NB_CHAN-1:0]    elig;
  logic                  gnt_vld;
  logic [CHW-1:0]        gnt_idx;
  logic [CHW:0]          cand;
  logic [EVNT_WIDTH-1:0] gnt_data;
  logic                  full_c;
  logic                  push;
  logic                  accept;

  // Read tokens are only ever observed after the full synchroniser chain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
    end else begin
      sync_q[0] <= events_rp_i;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end
  assign rp_sync = sync_q[SYNC_STAGES-1];

  // Round-robin search starting at rr_q; a channel acked last cycle sits out one cycle.
  always_comb begin
    elig    = evt_valid_i & ~ack_q;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NB_CHAN; i++) begin
      cand = {1'b0, rr_q} + (CHW+1)'(i);
      if (cand >= (CHW+1)'(NB_CHAN)) cand = cand - (CHW+1)'(NB_CHAN);
      if (!gnt_vld && elig[cand[CHW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[CHW-1:0];
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NB_CHAN; k++)
      if (gnt_idx == CHW'(k)) gnt_data = evt_data_i[k*EVNT_WIDTH +: EVNT_WIDTH];
    full_c = 1'b0;
    for (int s = 0; s < BUFFER_WIDTH; s++)
      if (wp_q == WPW'(s)) full_c = wt_q[s] ^ rp_sync[s];
  end

  assign push   = gnt_vld && !full_c;
  assign accept = gnt_vld && (!full_c || (DROP_ON_FULL != 0));

  always_comb begin
    wt_d = wt_q;
    for (int s = 0; s < BUFFER_WIDTH; s++)
      if (push && wp_q == WPW'(s)) wt_d[s] = ~wt_q[s];
    ack_d = '0;
    for (int k = 0; k < NB_CHAN; k++)
      ack_d[k] = accept && (gnt_idx == CHW'(k));
    wp_d = wp_q;
    if (push) wp_d = (wp_q == WP_LAST) ? '0 : wp_q + 1'b1;
    rr_d = rr_q;
    if (accept) rr_d = (gnt_idx == CH_LAST) ? '0 : gnt_idx + 1'b1;
    drop_d = drop_q;
    if ((DROP_ON_FULL != 0) && gnt_vld && full_c && drop_q != 16'hFFFF)
      drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wt_q   <= '0;
      ack_q  <= '0;
      wp_q   <= '0;
      rr_q   <= '0;
      drop_q <= '0;
    end else begin
      wt_q   <= wt_d;
      ack_q  <= ack_d;
      wp_q   <= wp_d;
      rr_q   <= rr_d;
      drop_q <= drop_d;
    end
  end

  // Each slot only loads on a push that targets it.
  generate
    for (genvar gi = 0; gi < BUFFER_WIDTH; gi++) begin : g_slot
      logic [EVNT_WIDTH-1:0] slot_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) slot_q <= '0;
        else if (push && wp_q == WPW'(gi)) slot_q <= gnt_data;
      end
      assign events_da_o[gi*EVNT_WIDTH +: EVNT_WIDTH] = slot_q;
    end
  endgenerate

  assign evt_ack_o   = ack_q;
  assign events_wt_o = wt_q;
  assign full_o      = full_c;
  assign drop_cnt_o  = drop_q;

endmodule

// File: tb/tb_soc_event_bus_tx.sv
// Bench for soc_event_bus_tx: slot-ring model checked every cycle plus directed
// scenarios; a second instance covers drop-on-full behaviour.
module tb_soc_event_bus_tx;
  localparam int NB = 4, EW = 8, BW = 8, SS = 2;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic [NB-1:0]    evt_valid_i = '0;
  logic [NB*EW-1:0] evt_data_i  = '0;
  logic [NB-1:0]    evt_ack_o;
  logic [BW-1:0]    events_wt_o;
  logic [BW-1:0]    events_rp_i = '0;
  logic [BW*EW-1:0] events_da_o;
  logic             full_o;
  logic [15:0]      drop_cnt_o;

  logic [NB-1:0]    d_valid = '0;
  logic [NB*EW-1:0] d_data  = '0;
  logic [NB-1:0]    d_ack;
  logic [BW-1:0]    d_wt;
  logic [BW-1:0]    d_rp = '0;
  logic [BW*EW-1:0] d_da;
  logic             d_full;
  logic [15:0]      d_drop;

  soc_event_bus_tx #(.NB_CHAN(NB), .EVNT_WIDTH(EW), .BUFFER_WIDTH(BW),
                     .SYNC_STAGES(SS), .DROP_ON_FULL(0)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .evt_valid_i(evt_valid_i), .evt_data_i(evt_data_i),
    .evt_ack_o(evt_ack_o), .events_wt_o(events_wt_o), .events_rp_i(events_rp_i),
    .events_da_o(events_da_o), .full_o(full_o), .drop_cnt_o(drop_cnt_o));

  soc_event_bus_tx #(.NB_CHAN(NB), .EVNT_WIDTH(EW), .BUFFER_WIDTH(BW),
                     .SYNC_STAGES(SS), .DROP_ON_FULL(1)) dut_d (
    .clk_i(clk_i), .rst_i(rst_i), .evt_valid_i(d_valid), .evt_data_i(d_data),
    .evt_ack_o(d_ack), .events_wt_o(d_wt), .events_rp_i(d_rp),
    .events_da_o(d_da), .full_o(d_full), .drop_cnt_o(d_drop));

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- event sources ----------------
  int         remaining [NB];
  int         seq [NB];
  logic [7:0] base [NB];

  task automatic apply_inputs();
    for (int k = 0; k < NB; k++) begin
      evt_valid_i[k] = (remaining[k] > 0);
      evt_data_i[k*EW +: EW] = base[k] + 8'(seq[k]);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (!rst_i)
        for (int k = 0; k < NB; k++)
          if (evt_ack_o[k]) begin
            if (remaining[k] > 0) remaining[k]--;
            seq[k]++;
          end
      apply_inputs();
    end
  end

  // ---------------- consumer ----------------
  bit         drain = 1'b0;
  int         rd = 0;
  logic [7:0] got [$];

  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (drain && !rst_i)
        for (int n = 0; n < BW; n++)
          if (events_wt_o[rd] !== events_rp_i[rd]) begin
            got.push_back(events_da_o[rd*EW +: EW]);
            events_rp_i[rd] = ~events_rp_i[rd];
            rd = (rd + 1) % BW;
          end
    end
  end

  // ---------------- reference model ----------------
  int            m_wp, m_rr;
  logic [BW-1:0] m_wt;
  logic [EW-1:0] m_slot [BW];
  logic [NB-1:0] m_ack;
  logic [BW-1:0] m_hist [SS];

  function automatic logic m_full();
    return m_wt[m_wp] != m_hist[SS-1][m_wp];
  endfunction

  initial begin
    bit mf;
    int g, c;
    forever begin
      @(posedge clk_i or posedge rst_i);
      if (rst_i) begin
        m_wp = 0; m_rr = 0; m_wt = '0; m_ack = '0;
        for (int s = 0; s < BW; s++) m_slot[s] = '0;
        for (int s = 0; s < SS; s++) m_hist[s] = '0;
      end else begin
        mf = m_full();
        g = -1;
        for (int i = 0; i < NB; i++) begin
          c = (m_rr + i) % NB;
          if (g < 0 && evt_valid_i[c] && !m_ack[c]) g = c;
        end
        m_ack = '0;
        for (int s = SS - 1; s > 0; s--) m_hist[s] = m_hist[s-1];
        m_hist[0] = events_rp_i;
        if (g >= 0 && !mf) begin
          m_slot[m_wp] = evt_data_i[g*EW +: EW];
          m_wt[m_wp]   = ~m_wt[m_wp];
          m_wp         = (m_wp + 1) % BW;
          m_rr         = (g + 1) % NB;
          m_ack[g]     = 1'b1;
        end
      end
    end
  end

  // ---------------- per-cycle compare and ack monitor ----------------
  int ack_cnt = 0, d_ack_cnt = 0, cyc = 0;
  int ack_log [$];
  int ack_cyc [$];

  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    logic [BW*EW-1:0] exp_da;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        for (int s = 0; s < BW; s++) exp_da[s*EW +: EW] = m_slot[s];
        check("cyc_ack",  64'(evt_ack_o), 64'(m_ack));
        check("cyc_wt",   64'(events_wt_o), 64'(m_wt));
        check("cyc_da",   64'(events_da_o), 64'(exp_da));
        check("cyc_full", 64'(full_o), 64'(m_full()));
        check("cyc_drop", 64'(drop_cnt_o), 64'd0);
        for (int k = 0; k < NB; k++) begin
          if (evt_ack_o[k]) begin
            ack_cnt++;
            ack_log.push_back(k);
            ack_cyc.push_back(cyc);
          end
          if (d_ack[k]) d_ack_cnt++;
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic do_reset();
    rst_i = 1'b1;
    drain = 1'b0;
    events_rp_i = '0;
    rd = 0;
    got.delete();
    for (int k = 0; k < NB; k++) begin
      remaining[k] = 0;
      seq[k] = 0;
    end
    apply_inputs();
    d_valid = '0;
    repeat (2) @(posedge clk_i);
    #2;
    ack_log.delete();
    ack_cyc.delete();
    ack_cnt = 0;
    d_ack_cnt = 0;
    rst_i = 1'b0;
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while (ack_cnt < target && n < budget) begin
      @(negedge clk_i);
      n++;
    end
    check(name, 64'(ack_cnt), 64'(target));
    @(posedge clk_i);
    #2;
  endtask

  task automatic d_send(input int ch, input logic [7:0] data);
    int  n = 0;
    bit  seen = 1'b0;
    @(posedge clk_i);
    #2;
    d_valid[ch] = 1'b1;
    d_data[ch*EW +: EW] = data;
    while (!seen && n < 8) begin
      @(posedge clk_i);
      #1;
      n++;
      if (d_ack[ch]) seen = 1'b1;
    end
    d_valid[ch] = 1'b0;
    check("drop_ack_latency", 64'(n), 64'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    bit seen;
    logic [BW*EW-1:0] snap;
    base[0] = 8'h30; base[1] = 8'h50; base[2] = 8'h70; base[3] = 8'hC0;
    for (int k = 0; k < NB; k++) begin
      remaining[k] = 0;
      seq[k] = 0;
    end
    apply_inputs();
    #1;
    check("rst_ack",  64'(evt_ack_o), 64'd0);
    check("rst_wt",   64'(events_wt_o), 64'd0);
    check("rst_da",   64'(events_da_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    check("rst_drop", 64'(drop_cnt_o), 64'd0);
    do_reset();

    // Single event on channel 2
    base[2] = 8'hA5;
    remaining[2] = 1;
    apply_inputs();
    @(posedge clk_i); #1;
    check("single_ack",   64'(evt_ack_o), 64'h4);
    check("single_wt",    64'(events_wt_o), 64'h01);
    check("single_slot0", 64'(events_da_o[7:0]), 64'hA5);
    @(posedge clk_i); #1;
    check("single_ack_pulse", 64'(evt_ack_o), 64'h0);

    // Round-robin across all channels with a draining consumer
    do_reset();
    drain = 1'b1;
    remaining[0] = 2; remaining[1] = 1; remaining[2] = 1; remaining[3] = 1;
    apply_inputs();
    wait_acks(5, 20, "rr_ack_count");
    for (int i = 0; i < 5; i++)
      if (i < ack_log.size()) check("rr_order", 64'(ack_log[i]), 64'(i % 4));
    if (ack_cyc.size() == 5) check("rr_back_to_back", 64'(ack_cyc[4] - ack_cyc[0]), 64'd4);
    check("rr_wt", 64'(events_wt_o), 64'h1F);

    // Backpressure with a stalled consumer
    do_reset();
    remaining[0] = 9;
    apply_inputs();
    wait_acks(8, 40, "bp_ack_count");
    repeat (4) @(posedge clk_i);
    #2;
    check("bp_ack_hold", 64'(ack_cnt), 64'd8);
    check("bp_wt",       64'(events_wt_o), 64'hFF);
    check("bp_full",     64'(full_o), 64'd1);
    check("bp_pending",  64'(remaining[0]), 64'd1);
    events_rp_i[0] = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 10) begin
      @(posedge clk_i); #1;
      n++;
      if (evt_ack_o[0]) seen = 1'b1;
    end
    check("bp_release_latency", 64'(n), 64'(SS + 1));
    check("bp_wt_after",        64'(events_wt_o), 64'hFE);
    check("bp_slot0_after",     64'(events_da_o[7:0]), 64'h38);

    // Drop mode on the second instance
    do_reset();
    for (int i = 0; i < 8; i++) d_send(0, 8'hD0 + 8'(i));
    snap = d_da;
    check("drop_fill_wt",   64'(d_wt), 64'hFF);
    check("drop_fill_full", 64'(d_full), 64'd1);
    check("drop_fill_slot7", 64'(d_da[63:56]), 64'hD7);
    for (int i = 0; i < 3; i++) d_send(1, 8'hE0 + 8'(i));
    @(negedge clk_i); #1;
    check("drop_ack_total", 64'(d_ack_cnt), 64'd11);
    check("drop_cnt",       64'(d_drop), 64'd3);
    check("drop_wt_kept",   64'(d_wt), 64'hFF);
    check("drop_da_kept",   64'(d_da), 64'(snap));

    // Wrap-around: 20 events through a keeping-pace consumer
    do_reset();
    drain = 1'b1;
    remaining[3] = 20;
    apply_inputs();
    wait_acks(20, 100, "wrap_ack_count");
    repeat (6) @(posedge clk_i);
    #2;
    check("wrap_got_count", 64'(got.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      if (i < got.size()) check("wrap_payload", 64'(got[i]), 64'(8'hC0 + 8'(i)));
    check("wrap_wt", 64'(events_wt_o), 64'h0F);

    // Reset in the middle of traffic
    do_reset();
    remaining[0] = 5;
    apply_inputs();
    wait_acks(5, 30, "mid_ack_count");
    remaining[1] = 1;
    apply_inputs();
    #2;
    rst_i = 1'b1;
    #1;
    check("mid_rst_ack",  64'(evt_ack_o), 64'd0);
    check("mid_rst_wt",   64'(events_wt_o), 64'd0);
    check("mid_rst_da",   64'(events_da_o), 64'd0);
    check("mid_rst_full", 64'(full_o), 64'd0);
    check("mid_rst_drop", 64'(drop_cnt_o), 64'd0);
    for (int k = 0; k < NB; k++) remaining[k] = 0;
    apply_inputs();
    repeat (2) @(posedge clk_i);
    #2;
    ack_cnt = 0;
    ack_log.delete();
    rst_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #2;
    check("mid_no_stale_ack", 64'(ack_cnt), 64'd0);
    remaining[1] = 1;
    apply_inputs();
    wait_acks(1, 10, "mid_rerequest_ack");
    if (ack_log.size() > 0) check("mid_rerequest_chan", 64'(ack_log[0]), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
